// File: rtl/dm_bytelane.sv
// Word-organised data memory with sb/sh/sw store narrowing and lb/lbu/lh/lhu/lw extraction; clears itself after reset.
// Latency: RD/LD combinational from the array (read-before-write); stores, align_err and store_cnt update on the rising edge.
// Backpressure: busy is high for DEPTH cycles after reset; stores are dropped and RD/LD read 0 while it is high.
module dm_bytelane #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [1:0]  StOp,
    input  logic [2:0]  LdOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic [31:0] LD,
    output logic        busy,
    output logic        align_err,
    output logic [15:0] store_cnt
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              align_err_q, align_err_d;
    logic [15:0]       store_cnt_q, store_cnt_d;

    logic [31:0]       mem_q [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_dat;

    logic [ADDR_W-1:0] idx;
    logic [31:0]       cur_word;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic              unused_addr_hi;

    // Upper address bits alias modulo DEPTH words.
    assign idx            = Addr[ADDR_W+1:2];
    assign cur_word       = mem_q[idx];
    assign unused_addr_hi = ^Addr[31:ADDR_W+2];

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        align_err_d = 1'b0;
        store_cnt_d = store_cnt_q;
        wr_en       = 1'b0;
        wr_idx      = idx;
        wr_dat      = cur_word;

        if (state_q == CLEAR) begin
            wr_en     = 1'b1;
            wr_idx    = clr_idx_q;
            wr_dat    = 32'h0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else if (WE) begin
            case (StOp)
                2'b00: begin
                    if (Addr[1:0] == 2'b00) begin
                        wr_en  = 1'b1;
                        wr_dat = WD;
                    end else begin
                        align_err_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (!Addr[0]) begin
                        wr_en = 1'b1;
                        if (Addr[1]) wr_dat[31:16] = WD[15:0];
                        else         wr_dat[15:0]  = WD[15:0];
                    end else begin
                        align_err_d = 1'b1;
                    end
                end
                2'b10: begin
                    wr_en = 1'b1;
                    wr_dat[{Addr[1:0], 3'b000} +: 8] = WD[7:0];
                end
                default: ;
            endcase
            if (wr_en) begin
                store_cnt_d = store_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            align_err_q <= 1'b0;
            store_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            align_err_q <= align_err_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Array has no reset of its own; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    always_comb begin
        RD       = (state_q == RUN) ? cur_word : 32'h0;
        half_sel = Addr[1] ? RD[31:16] : RD[15:0];
        byte_sel = RD[{Addr[1:0], 3'b000} +: 8];
        case (LdOp)
            3'b001:  LD = {{16{half_sel[15]}}, half_sel};
            3'b010:  LD = {16'h0, half_sel};
            3'b011:  LD = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  LD = {24'h0, byte_sel};
            default: LD = RD;
        endcase
    end

    assign busy      = (state_q == CLEAR);
    assign align_err = align_err_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_dm_bytelane.sv
// Randomized and directed bench for dm_bytelane against a byte-addressed reference model.
module tb_dm_bytelane;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [1:0]  StOp;
    logic [2:0]  LdOp;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [31:0] LD;
    logic        busy;
    logic        align_err;
    logic [15:0] store_cnt;

    int          nvec = 0;
    int          nmis = 0;

    logic [7:0]  mb [4096];
    logic [15:0] mcnt;

    dm_bytelane #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .WE        (WE),
        .StOp      (StOp),
        .LdOp      (LdOp),
        .Addr      (Addr),
        .WD        (WD),
        .RD        (RD),
        .LD        (LD),
        .busy      (busy),
        .align_err (align_err),
        .store_cnt (store_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int boff(input logic [31:0] a);
        return int'(a % 32'd4096);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int w;
        w = (boff(a) / 4) * 4;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
        int          w;
        int          h;
        int          b;
        logic [15:0] hv;
        logic [7:0]  bv;
        w  = (boff(a) / 4) * 4;
        h  = w + ((boff(a) / 2) % 2) * 2;
        b  = boff(a);
        hv = {mb[h+1], mb[h]};
        bv = mb[b];
        case (op)
            3'd1:    return 32'(signed'(hv));
            3'd2:    return {16'h0, hv};
            3'd3:    return 32'(signed'(bv));
            3'd4:    return {24'h0, bv};
            default: return m_word(a);
        endcase
    endfunction

    // Returns 0 = nothing, 1 = committed, 2 = misaligned reject.
    function automatic int m_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
        int b;
        b = boff(a);
        case (op)
            2'd0: begin
                if (b % 4 != 0) return 2;
                for (int i = 0; i < 4; i++) mb[b+i] = wd[8*i +: 8];
                return 1;
            end
            2'd1: begin
                if (b % 2 != 0) return 2;
                mb[b]   = wd[7:0];
                mb[b+1] = wd[15:8];
                return 1;
            end
            2'd2: begin
                mb[b] = wd[7:0];
                return 1;
            end
            default: return 0;
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        mcnt = 16'd0;
    endtask

    task automatic do_op(input logic we, input logic [1:0] st, input logic [2:0] ld,
                         input logic [31:0] a, input logic [31:0] wd);
        int s;
        @(negedge clk);
        WE = we; StOp = st; LdOp = ld; Addr = a; WD = wd;
        #1;
        check("rd", RD, m_word(a));
        check("ld", LD, m_load(ld, a));
        check("busy_run", {31'h0, busy}, 32'h0);
        s = we ? m_store(st, a, wd) : 0;
        if (s == 1) mcnt = mcnt + 16'd1;
        @(posedge clk);
        #1;
        check("align_err", {31'h0, align_err}, {31'h0, s == 2});
        check("store_cnt", {16'h0, store_cnt}, {16'h0, mcnt});
    endtask

    task automatic expect_load(input string tag, input logic [2:0] ld, input logic [31:0] a,
                               input logic [31:0] exp_rd, input logic [31:0] exp_ld);
        @(negedge clk);
        WE = 1'b0; LdOp = ld; Addr = a;
        #1;
        check({tag, "_rd"}, RD, exp_rd);
        check({tag, "_ld"}, LD, exp_ld);
    endtask

    task automatic sweep_len(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        WE = 1'b0;
        check(tag, n, 32'd1024);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; StOp = 2'b00; LdOp = 3'b000; Addr = 32'h0; WD = 32'h0;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_cnt", {16'h0, store_cnt}, 32'h0);
        check("rst_aerr", {31'h0, align_err}, 32'h0);
        check("clear_rd", RD, 32'h0);

        // Store attempt during the sweep, then reset again partway through.
        WE = 1'b1; StOp = 2'b00; Addr = 32'h0; WD = 32'hFFFF_FFFF;
        repeat (500) @(posedge clk);
        #1;
        check("mid_busy", {31'h0, busy}, 32'h1);
        check("mid_cnt", {16'h0, store_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sweep_len("sweep_len");
        check("post_cnt", {16'h0, store_cnt}, 32'h0);
        check("post_aerr", {31'h0, align_err}, 32'h0);
        expect_load("post_0", 3'd0, 32'h0, 32'h0, 32'h0);
        expect_load("post_ffc", 3'd0, 32'h0FFC, 32'h0, 32'h0);

        // Directed lane tests.
        do_op(1'b1, 2'd0, 3'd0, 32'h10, 32'h1234_5678);
        do_op(1'b1, 2'd2, 3'd0, 32'h11, 32'h0000_00AB);
        expect_load("lb11", 3'd3, 32'h11, 32'h1234_AB78, 32'hFFFF_FFAB);
        expect_load("lbu11", 3'd4, 32'h11, 32'h1234_AB78, 32'h0000_00AB);
        check("cnt2", {16'h0, store_cnt}, 32'd2);
        do_op(1'b1, 2'd1, 3'd0, 32'h12, 32'h0000_BEEF);
        expect_load("lh12", 3'd1, 32'h12, 32'hBEEF_AB78, 32'hFFFF_BEEF);
        expect_load("lhu12", 3'd2, 32'h12, 32'hBEEF_AB78, 32'h0000_BEEF);
        expect_load("lh10", 3'd1, 32'h10, 32'hBEEF_AB78, 32'hFFFF_AB78);

        // Misaligned stores: rejected, one-cycle error pulse.
        do_op(1'b1, 2'd0, 3'd0, 32'h21, 32'hDEAD_BEEF);
        do_op(1'b0, 2'd0, 3'd0, 32'h20, 32'h0);
        do_op(1'b1, 2'd1, 3'd0, 32'h23, 32'hDEAD_BEEF);
        do_op(1'b0, 2'd0, 3'd0, 32'h20, 32'h0);
        check("mis_cnt", {16'h0, store_cnt}, 32'd3);
        expect_load("mis_word", 3'd0, 32'h20, 32'h0, 32'h0);
        do_op(1'b1, 2'd3, 3'd0, 32'h20, 32'hFFFF_FFFF);

        // Aliasing above the array size.
        do_op(1'b1, 2'd0, 3'd0, 32'h1004, 32'hCAFE_F00D);
        expect_load("alias", 3'd0, 32'h4, 32'hCAFE_F00D, 32'hCAFE_F00D);

        for (int i = 0; i < 400; i++) begin
            do_op($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
                  ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127)), $urandom);
        end

        // Run the store counter up to its wrap point.
        while (mcnt != 16'hFFFF) begin
            @(negedge clk);
            WE = 1'b1; StOp = 2'd0; Addr = 32'h100; WD = {16'h0, mcnt};
            void'(m_store(2'd0, 32'h100, {16'h0, mcnt}));
            mcnt = mcnt + 16'd1;
            @(posedge clk);
        end
        #1;
        check("cnt_ffff", {16'h0, store_cnt}, 32'h0000_FFFF);
        do_op(1'b1, 2'd0, 3'd0, 32'h200, 32'h5555_AAAA);
        check("cnt_wrap", {16'h0, store_cnt}, 32'h0);
        expect_load("wrap_word", 3'd0, 32'h200, 32'h5555_AAAA, 32'h5555_AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dm_bytelane.md
Name: dm_bytelane

Overview:
- Data memory for the single-cycle MIPS datapath, word-organised, with byte and halfword store narrowing and load extraction.
- Stores narrow a 32-bit GPR value into byte/half lanes (sb/sh/sw).
- Loads return the raw word plus a lane-extracted, sign- or zero-extended result (lb/lbu/lh/lhu/lw).
- Sits between the ALU address output and the GRF write-back mux. After reset it clears its array with an internal sweep FSM.

Parameters:
DEPTH, 1024, number of 32-bit words; index = Addr[ADDR_W+1:2]
ADDR_W, 10, log2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
WE  input  1  store enable
StOp  input  2  00 sw, 01 sh, 10 sb, 11 reserved (treated as no store)
LdOp  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others read as lw
Addr  input  32  byte address from ALU
WD  input  32  store data (rt value)
RD  output  32  raw word at Addr[ADDR_W+1:2], combinational
LD  output  32  extracted/extended load result, combinational
busy  output  1  high while the clear sweep runs
align_err  output  1  registered; pulses one cycle after a rejected misaligned store
store_cnt  output  16  registered count of committed stores, wraps 0xFFFF->0

Behaviour:
- States: CLEAR, RUN.
- Reset (sampled high at an edge): state<=CLEAR, clr_idx<=0, align_err<=0, store_cnt<=0. Reset overrides any same-cycle store.
- CLEAR: each cycle writes word[clr_idx]<=0 and increments clr_idx. When clr_idx==DEPTH-1, write it and go to RUN. Clear takes exactly DEPTH cycles. busy=1 in CLEAR.
- CLEAR side effects: WE is ignored (no write, no count, no align_err). RD=LD=0.
- Reset asserted mid-CLEAR restarts the sweep at index 0.
- RUN: busy=0. Store commits at the rising edge when WE=1 and the store is aligned:
  - sw: needs Addr[1:0]==00; writes the full word.
  - sh: needs Addr[0]==0; lane Addr[1] (0 -> bits 15:0, 1 -> bits 31:16) <= WD[15:0]; other half unchanged.
  - sb: any Addr; lane Addr[1:0] (k -> bits 8k+7:8k) <= WD[7:0]; other bytes unchanged.
  - StOp==11: no write, no count, no error.
- Misaligned sw/sh with WE=1: no write; align_err<=1 for the next cycle only; store_cnt unchanged. align_err<=0 on every other RUN edge.
- store_cnt increments by 1 per committed store and wraps 0xFFFF->0.
- Addr bits above ADDR_W+1 are ignored (address aliases modulo DEPTH words).
- Load, combinational from the current array (read-before-write: a same-cycle store is visible only after the edge):
  - lw: LD = RD.
  - lh: sign-extend the half selected by Addr[1]. lhu: zero-extend the same half.
  - lb: sign-extend the byte selected by Addr[1:0]. lbu: zero-extend the same byte.
  - Load alignment is not checked; lh/lhu use Addr[1] only.

Test Plan:
- Reset 1 cycle, then hold reset low -> busy=1 for exactly 1024 cycles, falls on cycle 1025; read at Addr 0x0FFC gives RD=0; store_cnt=0.
- RUN, sw 0x12345678 @0x10, then sb WD=0xAB @0x11 -> RD=0x1234AB78; LdOp=lb @0x11 -> LD=0xFFFFFFAB; lbu -> 0x000000AB; store_cnt=2.
- sh WD=0x0000BEEF @0x12 on that word -> RD=0xBEEFAB78; lh @0x12 -> 0xFFFFBEEF; lhu -> 0x0000BEEF; lh @0x10 -> 0xFFFFAB78.
- sw @0x21 with WE=1 -> word 0x20 unchanged, align_err=1 one cycle then 0, store_cnt unchanged; same for sh @0x23.
- Store issued during CLEAR (WE=1, sw 0xFFFFFFFF @0x0) -> after sweep RD@0x0=0, store_cnt=0; reset reasserted at sweep cycle 500 -> busy lasts 1024 cycles from the new reset.
- Preload store_cnt to 0xFFFF via 65535 sw then one more sw -> store_cnt=0x0000; a store to Addr 0x1004 aliases to word index 1.
